// File: rtl/circle_pkg.sv
// Shared constants for the circle overlay and squared-distance units.
// Mode encoding plus the fixed pipeline latency for downstream alignment.
package circle_pkg;

  typedef enum logic {
    MODE_OUTLINE = 1'b0,
    MODE_FILLED  = 1'b1
  } mode_e;

  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/circle_dist2.sv
// Pipelined squared distance: |ax-bx|^2 + |ay-by|^2.
// Two register stages; the final sum is combinational for the caller's stage.
module circle_dist2 #(
  parameter int COORD_W = 8
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] by,
  output logic [2*COORD_W:0] d2
);

  localparam int DW = 2 * COORD_W;

  logic [COORD_W-1:0] dx_c, dy_c;
  logic [COORD_W-1:0] dx_q, dy_q;
  logic [DW-1:0]      dxw, dyw;
  logic [DW-1:0]      dx2_q, dy2_q;

  always_comb begin
    dx_c = (ax >= bx) ? ax - bx : bx - ax;
    dy_c = (ay >= by) ? ay - by : by - ay;
    dxw  = {{COORD_W{1'b0}}, dx_q};
    dyw  = {{COORD_W{1'b0}}, dy_q};
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      dx_q  <= '0;
      dy_q  <= '0;
      dx2_q <= '0;
      dy2_q <= '0;
    end else begin
      dx_q  <= dx_c;
      dy_q  <= dy_c;
      dx2_q <= dxw * dxw;
      dy2_q <= dyw * dyw;
    end
  end

  assign d2 = {1'b0, dx2_q} + {1'b0, dy2_q};

endmodule

// File: rtl/circle_overlay.sv
// Streaming circle overlay: tracks raster position, draws an outline or
// filled circle in a constant colour, three-cycle fixed latency.
module circle_overlay
  import circle_pkg::*;
#(
  parameter int                 PIXEL_W = 8,
  parameter int                 COORD_W = 8,
  parameter logic [PIXEL_W-1:0] COLOUR  = '1
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [PIXEL_W-1:0] PixelIn,
  input  logic               FrameIn,
  input  logic               LineIn,
  input  logic [COORD_W-1:0] Width,
  input  logic [COORD_W-1:0] Height,
  input  logic [COORD_W-1:0] CentreX,
  input  logic [COORD_W-1:0] CentreY,
  input  logic [COORD_W-1:0] Radius,
  input  logic               Mode,
  input  logic               Enable,
  output logic [PIXEL_W-1:0] PixelOut,
  output logic               FrameOut,
  output logic               LineOut
);

  localparam int                 DW   = 2 * COORD_W;
  localparam logic [COORD_W-1:0] CMAX = '1;
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  logic [COORD_W-1:0] x_q, y_q, cur_x, cur_y;

  logic [COORD_W-1:0] sh_cx, sh_cy, sh_r, sh_w, sh_h;
  mode_e              sh_mode;
  logic               sh_en;

  logic [COORD_W-1:0] eff_cx, eff_cy, eff_r, eff_w, eff_h;
  mode_e              eff_mode;
  logic               eff_en, inb_c;

  logic [PIXEL_W-1:0] pix1, pix2;
  logic               frm1, frm2, lin1, lin2;
  logic               inb1, inb2, en1, en2;
  mode_e              mode1, mode2;
  logic [COORD_W-1:0] r1;
  logic [DW-1:0]      rw, rsq2, rr2;

  logic [DW:0]        d2, lo, hi;
  logic               hit;

  // Coordinates of the pixel currently on PixelIn; saturate instead of wrap.
  always_comb begin
    cur_x = (x_q == CMAX) ? x_q : x_q + ONE;
    cur_y = y_q;
    priority case (1'b1)
      FrameIn: begin
        cur_x = '0;
        cur_y = '0;
      end
      LineIn: begin
        cur_x = '0;
        cur_y = (y_q == CMAX) ? y_q : y_q + ONE;
      end
      default: ;
    endcase
  end

  // The FrameIn pixel already sees the freshly captured configuration.
  always_comb begin
    eff_cx   = FrameIn ? CentreX       : sh_cx;
    eff_cy   = FrameIn ? CentreY       : sh_cy;
    eff_r    = FrameIn ? Radius        : sh_r;
    eff_w    = FrameIn ? Width         : sh_w;
    eff_h    = FrameIn ? Height        : sh_h;
    eff_mode = FrameIn ? mode_e'(Mode) : sh_mode;
    eff_en   = FrameIn ? Enable        : sh_en;
    inb_c    = (cur_x < eff_w) && (cur_y < eff_h);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      x_q     <= '0;
      y_q     <= '0;
      sh_cx   <= '0;
      sh_cy   <= '0;
      sh_r    <= '0;
      sh_w    <= '0;
      sh_h    <= '0;
      sh_mode <= MODE_OUTLINE;
      sh_en   <= 1'b0;
    end else begin
      x_q <= cur_x;
      y_q <= cur_y;
      if (FrameIn) begin
        sh_cx   <= CentreX;
        sh_cy   <= CentreY;
        sh_r    <= Radius;
        sh_w    <= Width;
        sh_h    <= Height;
        sh_mode <= mode_e'(Mode);
        sh_en   <= Enable;
      end
    end
  end

  circle_dist2 #(
    .COORD_W(COORD_W)
  ) u_dist2 (
    .Clk   (Clk),
    .nReset(nReset),
    .ax    (cur_x),
    .bx    (eff_cx),
    .ay    (cur_y),
    .by    (eff_cy),
    .d2    (d2)
  );

  assign rw = {{COORD_W{1'b0}}, r1};

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pix1  <= '0;
      frm1  <= 1'b0;
      lin1  <= 1'b0;
      inb1  <= 1'b0;
      en1   <= 1'b0;
      mode1 <= MODE_OUTLINE;
      r1    <= '0;
      pix2  <= '0;
      frm2  <= 1'b0;
      lin2  <= 1'b0;
      inb2  <= 1'b0;
      en2   <= 1'b0;
      mode2 <= MODE_OUTLINE;
      rsq2  <= '0;
      rr2   <= '0;
    end else begin
      pix1  <= PixelIn;
      frm1  <= FrameIn;
      lin1  <= LineIn;
      inb1  <= inb_c;
      en1   <= eff_en;
      mode1 <= eff_mode;
      r1    <= eff_r;
      pix2  <= pix1;
      frm2  <= frm1;
      lin2  <= lin1;
      inb2  <= inb1;
      en2   <= en1;
      mode2 <= mode1;
      rsq2  <= rw * rw;
      rr2   <= rw;
    end
  end

  // r^2 >= r for any unsigned r, so the lower band edge cannot underflow.
  always_comb begin
    lo  = {1'b0, rsq2} - {1'b0, rr2};
    hi  = {1'b0, rsq2} + {1'b0, rr2};
    hit = (d2 <= hi);
    if (mode2 == MODE_OUTLINE) hit = hit && (d2 >= lo);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      PixelOut <= '0;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
    end else begin
      PixelOut <= (en2 && inb2 && hit) ? COLOUR : pix2;
      FrameOut <= frm2;
      LineOut  <= lin2;
    end
  end

endmodule

// File: tb/tb_circle_overlay.sv
// Bench for circle_overlay: directed point table, scripted corner cases
// and random frames checked against a geometric reference model.
module tb_circle_overlay;
  import circle_pkg::*;

  typedef struct {
    int cx, cy, r, w, h, mode, en;
  } cfg_t;

  typedef struct {
    logic [7:0] pix;
    logic       frm, lin;
    int         x, y;
  } ent_t;

  typedef struct {
    int         mode, cx, cy, r, w, h, fw, fh, x, y;
    logic [7:0] exp;
  } vec_t;

  logic       Clk = 1'b0;
  logic       nReset = 1'b1;
  logic [7:0] PixelIn = '0;
  logic       FrameIn = 1'b0, LineIn = 1'b0;
  logic [7:0] Width, Height, CentreX, CentreY, Radius;
  logic       Mode, Enable;
  logic [7:0] PixelOut;
  logic       FrameOut, LineOut;

  cfg_t cfg = '{default: 0};
  cfg_t sh;
  ent_t q[$];
  int   mx, my;
  int   checks = 0, errors = 0;
  int   watch_on = 0, watch_x, watch_y, watch_seen;
  logic [7:0] watch_exp;
  vec_t tbl[16];

  assign Width   = 8'(cfg.w);
  assign Height  = 8'(cfg.h);
  assign CentreX = 8'(cfg.cx);
  assign CentreY = 8'(cfg.cy);
  assign Radius  = 8'(cfg.r);
  assign Mode    = (cfg.mode != 0);
  assign Enable  = (cfg.en != 0);

  circle_overlay dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .PixelIn (PixelIn),
    .FrameIn (FrameIn),
    .LineIn  (LineIn),
    .Width   (Width),
    .Height  (Height),
    .CentreX (CentreX),
    .CentreY (CentreY),
    .Radius  (Radius),
    .Mode    (Mode),
    .Enable  (Enable),
    .PixelOut(PixelOut),
    .FrameOut(FrameOut),
    .LineOut (LineOut)
  );

  always #5 Clk = ~Clk;

  // Geometric rule: squared Euclidean distance against the r^2 +/- r band.
  function automatic logic [7:0] model_pix(int x, int y, logic [7:0] p, cfg_t c);
    int  d2, r2;
    bit  hit, inb;
    d2  = (x - c.cx) * (x - c.cx) + (y - c.cy) * (y - c.cy);
    r2  = c.r * c.r;
    inb = (x < c.w) && (y < c.h);
    if (c.mode != 0) hit = (d2 <= r2 + c.r);
    else hit = (d2 >= r2 - c.r) && (d2 <= r2 + c.r);
    return (c.en != 0 && inb && hit) ? 8'hFF : p;
  endfunction

  task automatic reset_model();
    q.delete();
    repeat (PIPE_LAT) q.push_back('{pix: 8'h00, frm: 1'b0, lin: 1'b0, x: -1, y: -1});
    sh = '{default: 0};
    mx = 0;
    my = 0;
  endtask

  task automatic check_out();
    ent_t e;
    e = q.pop_front();
    checks++;
    if (PixelOut !== e.pix || FrameOut !== e.frm || LineOut !== e.lin) begin
      errors++;
      $display("FAIL stream (%0d,%0d): got pix=%h frm=%b lin=%b, want pix=%h frm=%b lin=%b",
               e.x, e.y, PixelOut, FrameOut, LineOut, e.pix, e.frm, e.lin);
    end
    if (watch_on != 0 && e.x >= 0 && e.x == watch_x && e.y == watch_y) begin
      watch_seen = 1;
      checks++;
      if (PixelOut !== watch_exp) begin
        errors++;
        $display("FAIL point (%0d,%0d): got %h, want %h", e.x, e.y, PixelOut, watch_exp);
      end
    end
  endtask

  task automatic drive(logic [7:0] p, logic f, logic l);
    PixelIn = p;
    FrameIn = f;
    LineIn  = l;
    if (f) begin
      mx = 0;
      my = 0;
      sh = cfg;
    end else if (l) begin
      mx = 0;
      my = (my < 255) ? my + 1 : 255;
    end else begin
      mx = (mx < 255) ? mx + 1 : 255;
    end
    q.push_back('{pix: model_pix(mx, my, p, sh), frm: f, lin: l, x: mx, y: my});
  endtask

  task automatic cyc(logic [7:0] p, logic f, logic l);
    @(negedge Clk);
    check_out();
    drive(p, f, l);
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.cx   = $urandom_range(0, 40);
    c.cy   = $urandom_range(0, 40);
    c.r    = $urandom_range(0, 20);
    c.w    = $urandom_range(0, 40);
    c.h    = $urandom_range(0, 40);
    c.mode = $urandom_range(0, 1);
    c.en   = ($urandom_range(0, 3) != 0) ? 1 : 0;
    return c;
  endfunction

  task automatic run_frame(int fw, int fh, bit rpix, int chg_y, int chg_r, bit rcfg);
    logic [7:0] p;
    watch_seen = 0;
    for (int y = 0; y < fh; y++) begin
      for (int x = 0; x < fw; x++) begin
        if (x == 0 && y == chg_y) cfg.r = chg_r;
        if (x == 0 && y > 0 && rcfg && $urandom_range(0, 3) == 0) cfg = rand_cfg();
        p = rpix ? 8'($urandom_range(0, 255)) : 8'h10;
        cyc(p, (x == 0 && y == 0), (x == 0 && y > 0));
      end
    end
    repeat (PIPE_LAT) cyc(8'h10, 1'b0, 1'b0);
    if (watch_on != 0) begin
      checks++;
      if (watch_seen == 0) begin
        errors++;
        $display("FAIL point (%0d,%0d): never reached, want %h", watch_x, watch_y, watch_exp);
      end
    end
  endtask

  task automatic set_watch(int x, int y, logic [7:0] e);
    watch_on  = 1;
    watch_x   = x;
    watch_y   = y;
    watch_exp = e;
  endtask

  initial begin
    tbl[0]  = '{0, 10, 10, 5, 32, 32, 32, 32, 15, 10, 8'hFF};
    tbl[1]  = '{0, 10, 10, 5, 32, 32, 32, 32, 14, 13, 8'hFF};
    tbl[2]  = '{0, 10, 10, 5, 32, 32, 32, 32, 10,  5, 8'hFF};
    tbl[3]  = '{0, 10, 10, 5, 32, 32, 32, 32, 13, 13, 8'h10};
    tbl[4]  = '{0, 10, 10, 5, 32, 32, 32, 32, 10, 10, 8'h10};
    tbl[5]  = '{1, 10, 10, 5, 32, 32, 32, 32, 10, 10, 8'hFF};
    tbl[6]  = '{1, 10, 10, 5, 32, 32, 32, 32, 13, 13, 8'hFF};
    tbl[7]  = '{1, 10, 10, 5, 32, 32, 32, 32, 15, 10, 8'hFF};
    tbl[8]  = '{1, 10, 10, 5, 32, 32, 32, 32, 16, 10, 8'h10};
    tbl[9]  = '{0,  2,  2, 5, 16, 16, 20, 20,  7,  2, 8'hFF};
    tbl[10] = '{1,  2,  2, 5, 16, 16, 20, 20,  0,  0, 8'hFF};
    tbl[11] = '{0,  2,  2, 0, 16, 16, 20, 20,  2,  2, 8'hFF};
    tbl[12] = '{1,  2,  2, 0, 16, 16, 20, 20,  3,  2, 8'h10};
    tbl[13] = '{1,  2,  2, 5,  0, 16, 20, 20,  2,  2, 8'h10};
    tbl[14] = '{1, 14, 14, 5, 16, 16, 20, 20, 15, 15, 8'hFF};
    tbl[15] = '{1, 14, 14, 5, 16, 16, 20, 20, 17, 14, 8'h10};

    #1 nReset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (PixelOut !== 8'h00 || FrameOut !== 1'b0 || LineOut !== 1'b0) begin
      errors++;
      $display("FAIL reset: got pix=%h frm=%b lin=%b, want all zero", PixelOut, FrameOut, LineOut);
    end
    @(posedge Clk);
    #2 nReset = 1'b1;
    reset_model();

    for (int i = 0; i < 16; i++) begin
      cfg = '{cx: tbl[i].cx, cy: tbl[i].cy, r: tbl[i].r, w: tbl[i].w,
              h: tbl[i].h, mode: tbl[i].mode, en: 1};
      set_watch(tbl[i].x, tbl[i].y, tbl[i].exp);
      run_frame(tbl[i].fw, tbl[i].fh, 1'b0, -1, 0, 1'b0);
    end

    cfg = '{cx: 10, cy: 10, r: 5, w: 32, h: 32, mode: 0, en: 1};
    set_watch(15, 10, 8'hFF);
    run_frame(32, 32, 1'b0, 3, 8, 1'b0);
    set_watch(18, 10, 8'hFF);
    run_frame(32, 32, 1'b0, -1, 0, 1'b0);
    watch_on = 0;

    cfg = rand_cfg();
    cfg.en = 0;
    run_frame(24, 24, 1'b1, -1, 0, 1'b0);

    cfg = '{cx: 0, cy: 0, r: 3, w: 255, h: 255, mode: 1, en: 1};
    run_frame(300, 1, 1'b1, -1, 0, 1'b0);
    run_frame(1, 300, 1'b1, -1, 0, 1'b0);

    repeat (6) begin
      cfg = rand_cfg();
      run_frame($urandom_range(1, 40), $urandom_range(1, 40), 1'b1, -1, 0, 1'b1);
    end

    cfg = '{cx: 10, cy: 10, r: 5, w: 32, h: 32, mode: 0, en: 1};
    for (int i = 0; i < 80; i++)
      cyc(8'h10, (i == 0), (i > 0 && i % 32 == 0));
    @(posedge Clk);
    #2 nReset = 1'b0;
    #1;
    checks++;
    if (PixelOut !== 8'h00 || FrameOut !== 1'b0 || LineOut !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got pix=%h frm=%b lin=%b, want all zero", PixelOut, FrameOut, LineOut);
    end
    FrameIn = 1'b0;
    LineIn  = 1'b0;
    repeat (2) @(posedge Clk);
    #2 nReset = 1'b1;
    reset_model();
    for (int i = 0; i < 40; i++)
      cyc(8'h10, 1'b0, (i % 32 == 0));
    set_watch(15, 10, 8'hFF);
    run_frame(32, 32, 1'b0, -1, 0, 1'b0);
    watch_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
